// File: rtl/model_cycle_sequencer_if.sv
// Bench-top <-> cycle sequencer connection: run control, run status, and the
// call/response port towards the multi-channel cache model.
interface model_cycle_sequencer_if #(
  parameter int NUM_CH = 4,
  parameter int CYC_W  = 32
);
  logic                   start;
  logic                   step_en;
  logic                   stop;
  logic [NUM_CH-1:0]      ch_mask;
  logic [CYC_W-1:0]       max_cycles;

  logic                   busy;
  logic                   done;
  logic [CYC_W-1:0]       cycle_cnt;
  logic [NUM_CH-1:0]      ch_active;
  logic [NUM_CH-1:0]      ch_done;
  logic [2:0]             exit_code;

  // Each *_call strobe is a model call taken at the next rising clock edge.
  // status per channel: 0 stalled, 1 progressed, 2 finished, 3 error (<0).
  logic                   init_call;
  logic [255:0]           init_file;
  logic [31:0]            init_verbose;
  logic                   init_dump_csv;
  logic [31:0]            init_num_ch;
  logic                   cycle_call;
  logic [NUM_CH-1:0]      call_mask;
  logic [CYC_W-1:0]       call_cycle;
  logic [NUM_CH-1:0][1:0] status;
  logic                   final_call;

  modport master (
    output start, step_en, stop, ch_mask, max_cycles, status,
    input  busy, done, cycle_cnt, ch_active, ch_done, exit_code,
    input  init_call, init_file, init_verbose, init_dump_csv, init_num_ch,
    input  cycle_call, call_mask, call_cycle, final_call
  );

  modport slave (
    input  start, step_en, stop, ch_mask, max_cycles, status,
    output busy, done, cycle_cnt, ch_active, ch_done, exit_code,
    output init_call, init_file, init_verbose, init_dump_csv, init_num_ch,
    output cycle_call, call_mask, call_cycle, final_call
  );
endinterface

// File: rtl/model_cycle_sequencer.sv
// Lifecycle driver for a multi-channel cache model: one init, lockstep
// per-channel cycle calls, one finalize, with completion/budget/timeout tracking.
module model_cycle_sequencer #(
  parameter int           NUM_CH     = 4,
  parameter int           CYC_W      = 32,
  parameter int           TIMEOUT    = 1024,
  parameter logic [255:0] INSTR_FILE = 256'("instruction.txt"),
  parameter int           VERBOSE    = 1,
  parameter bit           DUMP_CSV   = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  model_cycle_sequencer_if.slave   bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] EXIT_NONE   = 3'd0;
  localparam logic [2:0] EXIT_ALL    = 3'd1;
  localparam logic [2:0] EXIT_BUDGET = 3'd2;
  localparam logic [2:0] EXIT_STOP   = 3'd3;
  localparam logic [2:0] EXIT_TMO    = 3'd4;
  localparam logic [2:0] EXIT_ERR    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_INIT = 3'd1,
    S_RUN  = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CYC_W-1:0]  max_q, max_d;
  logic [CYC_W-1:0]  cycle_q, cycle_d;
  logic [NUM_CH-1:0] active_q, active_d;
  logic [NUM_CH-1:0] chdone_q, chdone_d;
  logic [2:0]        exit_q, exit_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic              step_s;
  logic [NUM_CH-1:0] fin_s;
  logic              err_s;
  logic              prog_s;
  logic [2:0]        cause_s;

  // Next-state: run launch, per-step status fold and exit cause selection.
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    cycle_d  = cycle_q;
    active_d = active_q;
    chdone_d = chdone_q;
    exit_d   = exit_q;
    tmo_d    = tmo_q;
    step_s   = 1'b0;
    fin_s    = '0;
    err_s    = 1'b0;
    prog_s   = 1'b0;
    cause_s  = EXIT_NONE;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_INIT;
          max_d    = bus.max_cycles;
          cycle_d  = '0;
          active_d = bus.ch_mask;
          chdone_d = '0;
          exit_d   = EXIT_NONE;
          tmo_d    = '0;
        end else begin
          state_d  = state_q;
        end
      end
      S_INIT: state_d = S_RUN;
      S_RUN: begin
        if (bus.step_en && (active_q != '0)) begin
          step_s = 1'b1;
          for (int c = 0; c < NUM_CH; c++) begin
            if (active_q[c]) begin
              case (bus.status[c])
                2'd1:    prog_s = 1'b1;
                2'd2:    begin fin_s[c] = 1'b1; prog_s = 1'b1; end
                2'd3:    err_s = 1'b1;
                default: prog_s = prog_s;
              endcase
            end else begin
              fin_s[c] = 1'b0;
            end
          end
          active_d = active_q & ~fin_s;
          chdone_d = chdone_q | fin_s;
          cycle_d  = cycle_q + CYC_W'(1);
          tmo_d    = prog_s ? '0 : (tmo_q + TW'(1));
        end else begin
          step_s = 1'b0;
        end
        // Exit checks look at the values this clock will commit.
        if (err_s)                                                   cause_s = EXIT_ERR;
        else if (active_d == '0)                                     cause_s = EXIT_ALL;
        else if (step_s && (max_q != '0) && (cycle_d == max_q))      cause_s = EXIT_BUDGET;
        else if (step_s && (tmo_d == TW'(TIMEOUT)))                  cause_s = EXIT_TMO;
        else if (bus.stop)                                           cause_s = EXIT_STOP;
        else                                                         cause_s = EXIT_NONE;
        if (cause_s != EXIT_NONE) begin
          state_d = S_FIN;
          exit_d  = cause_s;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIN:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and run bookkeeping registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      max_q    <= '0;
      cycle_q  <= '0;
      active_q <= '0;
      chdone_q <= '0;
      exit_q   <= EXIT_NONE;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      cycle_q  <= cycle_d;
      active_q <= active_d;
      chdone_q <= chdone_d;
      exit_q   <= exit_d;
      tmo_q    <= tmo_d;
    end
  end

  assign bus.busy      = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_FIN);
  assign bus.done      = (state_q == S_DONE);
  assign bus.cycle_cnt = cycle_q;
  assign bus.ch_active = active_q;
  assign bus.ch_done   = chdone_q;
  assign bus.exit_code = exit_q;

  // A reset on the calling edge cancels the call.
  assign bus.init_call     = (state_q == S_INIT) && !reset;
  assign bus.init_file     = INSTR_FILE;
  assign bus.init_verbose  = 32'(VERBOSE);
  assign bus.init_dump_csv = DUMP_CSV;
  assign bus.init_num_ch   = 32'(NUM_CH);
  assign bus.cycle_call    = step_s && !reset;
  assign bus.call_mask     = (step_s && !reset) ? active_q : '0;
  assign bus.call_cycle    = cycle_q;
  assign bus.final_call    = (state_q == S_FIN) && !reset;

endmodule

// File: tb/tb_model_cycle_sequencer.sv
// Self-checking bench: the bench plays the cache model and compares run results
// against a table of known runs, a stepped-cycle reference model, and sequences.
module tb_model_cycle_sequencer;
  localparam int NCH = 4;
  localparam int CW  = 32;
  localparam int TMO = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  model_cycle_sequencer_if #(.NUM_CH(NCH), .CYC_W(CW)) m();

  model_cycle_sequencer #(.NUM_CH(NCH), .CYC_W(CW), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (m.slave)
  );

  // Model behaviour per channel: error cycle, finish cycle, progress period (0 = never).
  int fin_at [NCH];
  int err_at [NCH];
  int period [NCH];

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [1:0] model_status(int c, int cyc);
    if (err_at[c] == cyc)                              return 2'd3;
    else if (fin_at[c] == cyc)                         return 2'd2;
    else if (period[c] != 0 && (cyc % period[c]) == 0) return 2'd1;
    else                                               return 2'd0;
  endfunction

  always_comb begin
    for (int c = 0; c < NCH; c++) m.status[c] = model_status(c, int'(m.call_cycle));
  end

  int n_init  = 0;
  int n_fin   = 0;
  int n_calls = 0;
  always @(posedge clock) begin
    if (m.init_call)  n_init  <= n_init + 1;
    if (m.final_call) n_fin   <= n_fin + 1;
    if (m.cycle_call) n_calls <= n_calls + $countones(m.call_mask);
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk stepped cycles only; idle clocks never change the outcome.
  task automatic ref_model(input logic [3:0] mask, input int maxc,
                           output int e_cnt, output logic [3:0] e_done,
                           output logic [3:0] e_act, output int e_exit, output int e_calls);
    int tmo;
    bit prog, err;
    e_cnt = 0; e_done = 4'h0; e_act = mask; e_exit = 0; e_calls = 0; tmo = 0;
    if (mask == 4'h0) begin
      e_exit = 1;
      return;
    end
    for (int k = 0; k < 100000; k++) begin
      prog = 1'b0; err = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (e_act[c]) begin
          e_calls++;
          case (model_status(c, e_cnt))
            2'd1: prog = 1'b1;
            2'd2: begin prog = 1'b1; e_act[c] = 1'b0; e_done[c] = 1'b1; end
            2'd3: err = 1'b1;
            default: ;
          endcase
        end
      end
      e_cnt++;
      tmo = prog ? 0 : tmo + 1;
      if (err)                            begin e_exit = 5; return; end
      if (e_act == 4'h0)                  begin e_exit = 1; return; end
      if (maxc != 0 && e_cnt == maxc)     begin e_exit = 2; return; end
      if (tmo == TMO)                     begin e_exit = 4; return; end
    end
  endtask

  task automatic start_run(input logic [3:0] mask, input logic [31:0] maxc);
    @(negedge clock);
    m.ch_mask = mask; m.max_cycles = maxc; m.start = 1'b1;
    @(negedge clock);
    m.start = 1'b0;
  endtask

  // mode: 0 step always, 1 toggle, 2 random
  task automatic run_to_done(input string tag, input int mode);
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (m.done) begin ok = 1'b1; break; end
      m.step_en = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 2) == 0) : ($urandom_range(0, 3) != 0);
    end
    m.step_en = 1'b0;
    chk({tag, "_reaches_done"}, 64'(ok), 64'd1);
  endtask

  task automatic set_ch(int c, int f, int e, int p);
    fin_at[c] = f; err_at[c] = e; period[c] = p;
  endtask

  task automatic check_run(input string tag, input int e_cnt, input logic [3:0] e_done,
                           input logic [3:0] e_act, input int e_exit, input int e_calls,
                           input int i0, input int f0, input int c0);
    chk({tag, "_cycle_cnt"}, 64'(m.cycle_cnt), 64'(e_cnt));
    chk({tag, "_ch_done"},   64'(m.ch_done),   64'(e_done));
    chk({tag, "_ch_active"}, 64'(m.ch_active), 64'(e_act));
    chk({tag, "_exit_code"}, 64'(m.exit_code), 64'(e_exit));
    chk({tag, "_calls"},     64'(n_calls - c0), 64'(e_calls));
    chk({tag, "_inits"},     64'(n_init - i0),  64'd1);
    chk({tag, "_finals"},    64'(n_fin - f0),   64'd1);
    chk({tag, "_busy"},      64'(m.busy),       64'd0);
  endtask

  typedef struct packed {
    logic [3:0]      mask;
    logic [31:0]     maxc;
    logic [3:0][7:0] fin;   // 8'hFF = never
    logic [3:0][7:0] err;   // 8'hFF = never
    logic [3:0][7:0] per;
    logic [1:0]      mode;
    logic [31:0]     e_cnt;
    logic [3:0]      e_done;
    logic [3:0]      e_act;
    logic [2:0]      e_exit;
    logic [15:0]     e_calls;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int i0, f0, c0, e_cnt, e_exit, e_calls;
    logic [3:0] e_done, e_act, r_mask;
    logic [31:0] r_max;

    vecs[0] = '{4'hF, 32'd0, {8'd39, 8'd29, 8'd19, 8'd9}, 32'hFFFFFFFF, 32'h01010101, 2'd0,
                32'd40, 4'hF, 4'h0, 3'd1, 16'd100};
    vecs[1] = '{4'h5, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01010101, 2'd0,
                32'd5, 4'h0, 4'h5, 3'd2, 16'd10};
    vecs[2] = '{4'h1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 2'd1,
                32'd8, 4'h0, 4'h1, 3'd4, 16'd8};
    vecs[3] = '{4'h3, 32'd0, {8'hFF, 8'hFF, 8'hFF, 8'd3}, {8'hFF, 8'hFF, 8'd3, 8'hFF}, 32'h01010101, 2'd0,
                32'd4, 4'h1, 4'h2, 3'd5, 16'd8};
    vecs[4] = '{4'h0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h01010101, 2'd0,
                32'd0, 4'h0, 4'h0, 3'd1, 16'd0};

    m.start = 1'b0; m.step_en = 1'b0; m.stop = 1'b0; m.ch_mask = '0; m.max_cycles = '0;
    for (int c = 0; c < NCH; c++) set_ch(c, -1, -1, 1);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 64'(m.busy), 64'd0);
    chk("rst_done", 64'(m.done), 64'd0);
    chk("rst_cycle_cnt", 64'(m.cycle_cnt), 64'd0);
    chk("rst_ch_active", 64'(m.ch_active), 64'd0);
    chk("rst_ch_done", 64'(m.ch_done), 64'd0);
    chk("rst_exit_code", 64'(m.exit_code), 64'd0);
    chk("init_num_ch", 64'(m.init_num_ch), 64'd4);
    chk("init_verbose", 64'(m.init_verbose), 64'd1);
    chk("init_dump_csv", 64'(m.init_dump_csv), 64'd1);
    chk("init_file", 64'(m.init_file == 256'("instruction.txt")), 64'd1);

    // Table-driven runs
    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < NCH; c++)
        set_ch(c, (vecs[v].fin[c] == 8'hFF) ? -1 : int'(vecs[v].fin[c]),
                  (vecs[v].err[c] == 8'hFF) ? -1 : int'(vecs[v].err[c]),
                  int'(vecs[v].per[c]));
      i0 = n_init; f0 = n_fin; c0 = n_calls;
      start_run(vecs[v].mask, vecs[v].maxc);
      run_to_done($sformatf("vec%0d", v), int'(vecs[v].mode));
      check_run($sformatf("vec%0d", v), int'(vecs[v].e_cnt), vecs[v].e_done, vecs[v].e_act,
                int'(vecs[v].e_exit), int'(vecs[v].e_calls), i0, f0, c0);
    end

    // Randomized runs against the reference model
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < NCH; c++)
        set_ch(c, ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 70)),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 50)) : -1,
                  int'($urandom_range(0, 4)));
      r_mask = 4'($urandom_range(0, 15));
      r_max  = 32'($urandom_range(1, 60));
      ref_model(r_mask, int'(r_max), e_cnt, e_done, e_act, e_exit, e_calls);
      i0 = n_init; f0 = n_fin; c0 = n_calls;
      start_run(r_mask, r_max);
      run_to_done($sformatf("rnd%0d", r), 2);
      check_run($sformatf("rnd%0d", r), e_cnt, e_done, e_act, e_exit, e_calls, i0, f0, c0);
    end

    // Stop with step_en low at cycle 7; start during RUN is ignored
    for (int c = 0; c < NCH; c++) set_ch(c, -1, -1, 1);
    i0 = n_init; f0 = n_fin; c0 = n_calls;
    start_run(4'hF, 32'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      m.start = (i == 3);
      if (m.cycle_cnt == 32'd7) break;
      m.step_en = 1'b1;
    end
    m.start = 1'b0; m.step_en = 1'b0; m.stop = 1'b1;
    chk("start_ignored_inits", 64'(n_init - i0), 64'd1);
    chk("start_ignored_busy", 64'(m.busy), 64'd1);
    @(negedge clock);
    m.stop = 1'b0;
    run_to_done("stop", 0);
    check_run("stop", 7, 4'h0, 4'hF, 3, 28, i0, f0, c0);

    // Restart from DONE clears counters and re-inits
    i0 = n_init; f0 = n_fin; c0 = n_calls;
    start_run(4'h0, 32'd0);
    chk("restart_cycle_cnt", 64'(m.cycle_cnt), 64'd0);
    chk("restart_exit_code", 64'(m.exit_code), 64'd0);
    chk("restart_busy", 64'(m.busy), 64'd1);
    run_to_done("restart", 0);
    check_run("restart", 0, 4'h0, 4'h0, 1, 0, i0, f0, c0);

    // Reset mid-RUN at cycle 12: straight to IDLE, no finalize
    f0 = n_fin;
    start_run(4'hF, 32'd0);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (m.cycle_cnt == 32'd12) break;
      m.step_en = 1'b1;
    end
    m.step_en = 1'b0;
    chk("pre_reset_cycle_cnt", 64'(m.cycle_cnt), 64'd12);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrun_rst_busy", 64'(m.busy), 64'd0);
    chk("midrun_rst_cycle_cnt", 64'(m.cycle_cnt), 64'd0);
    chk("midrun_rst_ch_active", 64'(m.ch_active), 64'd0);
    chk("midrun_rst_exit_code", 64'(m.exit_code), 64'd0);
    repeat (3) @(negedge clock);
    chk("midrun_rst_no_final", 64'(n_fin - f0), 64'd0);
    chk("midrun_rst_idle", 64'({m.busy, m.done}), 64'd0);

    // Reset on the INIT clock suppresses model_init
    i0 = n_init;
    start_run(4'hF, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("init_rst_no_init", 64'(n_init - i0), 64'd0);
    chk("init_rst_busy", 64'(m.busy), 64'd0);

    // Minimum run latency: start to done in 4 clocks
    c0 = n_calls;
    start_run(4'h0, 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("minrun_done_3clk", 64'(m.done), 64'd0);
    @(negedge clock);
    chk("minrun_done_4clk", 64'(m.done), 64'd1);
    chk("minrun_exit_code", 64'(m.exit_code), 64'd1);
    chk("minrun_calls", 64'(n_calls - c0), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/model_cycle_sequencer.md
# model_cycle_sequencer

Parametrised DPI driver that steps a multi-channel C cache model (NUM_CH independent cores/ports) in lockstep with the RTL bench. It owns the whole model lifecycle: one `model_init` per run, per-channel `model_cycle_ch` calls on enabled steps, and exactly one `model_finalize` per run. It tracks per-channel completion, run budget, no-progress timeout and exit cause, and reports them to the bench top.

## Interface
- NUM_CH, 4, number of model channels (1..32)
- CYC_W, 32, cycle counter / budget width
- TIMEOUT, 1024, consecutive stepped cycles without progress before abort (>=1)
- INSTR_FILE, "instruction.txt", trace file passed to model_init
- VERBOSE, 1, verbosity passed to model_init
- DUMP_CSV, 1, CSV dump enable passed to model_init
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a run; honoured only in IDLE or DONE
- step_en  in  1  advance the model one cycle this clock (RUN only)
- stop  in  1  request early end of run
- ch_mask  in  NUM_CH  channels enabled for the run, latched at start
- max_cycles  in  CYC_W  step budget, latched at start; 0 = unlimited
- busy  out  1  high in INIT, RUN, FIN
- done  out  1  high while in DONE
- cycle_cnt  out  CYC_W  steps executed this run
- ch_active  out  NUM_CH  channels still running
- ch_done  out  NUM_CH  channels that reported finished
- exit_code  out  3  0 none, 1 all done, 2 budget, 3 stop, 4 timeout, 5 model error

## Operation
- DPI imports: model_init(string file, int verbose, bit dump_csv, int num_ch); int model_cycle_ch(int ch, int cycle); model_finalize().
- model_cycle_ch return values: 0 = stalled, 1 = progressed, 2 = channel finished, <0 = error.
- FSM states: IDLE, INIT, RUN, FIN, DONE. Reset -> IDLE.
- IDLE/DONE + start: latch ch_mask, max_cycles; clear cycle_cnt, ch_done, exit_code, timeout counter; ch_active <= ch_mask; go INIT.
- INIT: call model_init exactly once; go RUN.
- RUN, step_en=1, ch_active!=0: call model_cycle_ch(ch, cycle_cnt) for every active channel in ascending index order; cycle_cnt += 1.
  - status 2: clear ch_active[ch], set ch_done[ch].
  - any status 1 or 2 this step: timeout counter <= 0, else +1.
- RUN, step_en=0: no DPI calls; cycle_cnt, timeout counter hold.
- RUN exit to FIN (evaluated on post-update values, same clock); exit_code priority:
  - 5: any status <0 this step.
  - 1: ch_active becomes 0 (includes ch_mask=0 at run start, with no DPI call).
  - 2: max_cycles!=0 and new cycle_cnt == max_cycles.
  - 4: timeout counter reaches TIMEOUT.
  - 3: stop=1 (honoured regardless of step_en).
- FIN: call model_finalize exactly once; go DONE.
- DONE: outputs hold; start restarts (new model_init).
- start in INIT/RUN/FIN: ignored.
- cycle_cnt with max_cycles=0 wraps modulo 2^CYC_W, run continues.

## Timing
- Reset values: busy 0, done 0, cycle_cnt 0, ch_active 0, ch_done 0, exit_code 0, state IDLE.
- Reset mid-run (any state): immediate return to IDLE next clock; no model_finalize call; reset during INIT clock suppresses model_init.
- start at edge N -> INIT at N+1 (model_init at edge N+1) -> RUN from N+2.
- First model_cycle_ch at first RUN edge with step_en=1, cycle argument 0.
- Exit condition at edge M -> FIN at M+1 (finalize at edge M+1) -> DONE/done=1 from M+2.
- All DPI calls made inside the clocked process; outputs reflect a step's results one clock after its edge.
- Minimum run (ch_mask=0): start to done = 4 clocks.

## Test plan
- NUM_CH=4, mask 4'b1111, model finishes ch0..3 at cycles 10,20,30,40, step_en=1 -> cycle_cnt=40, ch_done=4'b1111, exit_code=1, one init, one finalize.
- mask 4'b0101, max_cycles=5, model never finishes -> only ch0/ch2 called, cycle_cnt=5, ch_active=4'b0101, exit_code=2.
- TIMEOUT=8, model returns 0 always, step_en toggled 1/0 -> abort after 8 stepped cycles, cycle_cnt=8, exit_code=4.
- ch1 returns -1 at cycle 3 while ch0 returns 2 same step -> exit_code=5 (error wins), ch_done[0]=1.
- stop pulsed with step_en=0 at cycle 7 -> no further calls, cycle_cnt=7, exit_code=3; then start from DONE -> fresh init, counters cleared.
- reset asserted mid-RUN at cycle 12 -> IDLE, all outputs 0, no finalize call; mask 0 start -> done after 4 clocks, exit_code=1, zero model_cycle_ch calls.
